// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
//
// Pass/fail/timeout verdict source for RISC-V compliance runs. Watches the
// fetched instruction word of each monitored hart (channel) for signature
// codes, counts RUN cycles and latches a final verdict until re-armed.
//
// Optional feature: define RISCV_TEST_MONITOR_PC_STOP_EN to build a per-channel
// PC comparator that ends the run in STOP when a valid channel reaches STOP_PC.
// Without the macro pc is unused and status 5 is never produced.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle arm pulse (accepted in IDLE and terminal states)
//   i_read       in   CHANNELS*XLEN fetched words, channel c at [c*XLEN +: XLEN]
//   i_valid      in   CHANNELS qualifiers for i_read (and pc)
//   pc           in   CHANNELS*XLEN per-channel PC (optional feature only)
//   status       out  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 STOP
//   done         out  high in any terminal state
//   pass_mask    out  sticky per-channel pass flags
//   fail_chan    out  lowest channel index that raised FAIL
//   cycle_count  out  RUN edges completed before the verdict
//
// Handshake: there is no ready side. A channel's word (and pc) is sampled on
// every RUN edge where its i_valid bit is 1; with i_valid low the word is
// ignored entirely, X included. status is the FSM state register itself.

module riscv_test_monitor #(
    parameter int              XLEN           = 32,
    parameter int              CHANNELS       = 1,
    parameter logic [XLEN-1:0] PASS_CODE      = 'h0000_0001,
    parameter logic [XLEN-1:0] FAIL_CODE      = 'h0000_0000,
    parameter int              TIMEOUT_CYCLES = 49999,
    parameter int              CNT_W          = 32,
    parameter logic [XLEN-1:0] STOP_PC        = 'h0000_00A4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CHANNELS*XLEN-1:0] i_read,
    input  logic [CHANNELS-1:0]      i_valid,
    input  logic [CHANNELS*XLEN-1:0] pc,
    output logic [2:0]               status,
    output logic                     done,
    output logic [CHANNELS-1:0]      pass_mask,
    output logic [2:0]               fail_chan,
    output logic [CNT_W-1:0]         cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4,
        S_STOP    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                done_d;
    logic [CHANNELS-1:0] pass_mask_d;
    logic [2:0]          fail_chan_d;
    logic [CNT_W-1:0]    count_d;

    logic [CHANNELS-1:0] fail_hit;
    logic [CHANNELS-1:0] pass_hit;
    logic [2:0]          fail_idx;
    logic                stop_hit;

    // Per-channel signature matching. '&&' keeps a masked channel at 0 even
    // when its word is X.
    always_comb begin
        fail_hit = '0;
        pass_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            fail_hit[c] = i_valid[c] && (i_read[c*XLEN +: XLEN] == FAIL_CODE);
            pass_hit[c] = i_valid[c] && (i_read[c*XLEN +: XLEN] == PASS_CODE);
        end
    end

    // Walk downwards so the lowest failing index is the last one written.
    always_comb begin
        fail_idx = 3'd0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (fail_hit[c]) fail_idx = 3'(c);
        end
    end

`ifdef RISCV_TEST_MONITOR_PC_STOP_EN
    always_comb begin
        stop_hit = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_valid[c] && (pc[c*XLEN +: XLEN] == STOP_PC)) stop_hit = 1'b1;
        end
    end
`else
    // pc and STOP_PC are intentionally left without a load; no comparator.
    logic stop_unused;
    assign stop_unused = ^{pc, STOP_PC};
    assign stop_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pass_mask_d = pass_mask;
        fail_chan_d = fail_chan;
        count_d     = cycle_count;

        case (state_q)
            S_RUN: begin
                // start is ignored while running.
                if (|fail_hit) begin
                    state_d     = S_FAIL;
                    fail_chan_d = fail_idx;
                end else begin
                    pass_mask_d = pass_mask | pass_hit;
                    if (&pass_mask_d) begin
                        state_d = S_PASS;
                    end else if (stop_hit) begin
                        state_d = S_STOP;
                    end else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_TIMEOUT;
                    end else begin
                        count_d = cycle_count + 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and every terminal state: hold until armed.
                if (start) begin
                    state_d     = S_RUN;
                    pass_mask_d = '0;
                    fail_chan_d = 3'd0;
                    count_d     = '0;
                end
            end
        endcase

        done_d = (state_d == S_PASS) || (state_d == S_FAIL) ||
                 (state_d == S_TIMEOUT) || (state_d == S_STOP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            done        <= 1'b0;
            pass_mask   <= '0;
            fail_chan   <= 3'd0;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            done        <= done_d;
            pass_mask   <= pass_mask_d;
            fail_chan   <= fail_chan_d;
            cycle_count <= count_d;
        end
    end

    assign status = state_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor. Three instances:
//   u1 : CHANNELS=1, TIMEOUT_CYCLES=100
//   u4 : CHANNELS=4, TIMEOUT_CYCLES=100
//   ut : CHANNELS=2, TIMEOUT_CYCLES=8
// Inputs change 1 time unit after a rising edge; outputs are compared there
// as well, away from the active edge.

module tb_riscv_test_monitor;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] PASS = 32'h0000_0001;
    localparam logic [31:0] FAILW = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // u1
    logic        start1;
    logic [31:0] rd1, pc1;
    logic [0:0]  v1;
    logic [2:0]  st1, fc1;
    logic        dn1;
    logic [0:0]  pm1;
    logic [31:0] cnt1;

    // u4
    logic         start4;
    logic [127:0] rd4, pc4;
    logic [3:0]   v4;
    logic [2:0]   st4, fc4;
    logic         dn4;
    logic [3:0]   pm4;
    logic [31:0]  cnt4;

    // ut
    logic        startt;
    logic [63:0] rdt, pct;
    logic [1:0]  vt;
    logic [2:0]  stt, fct;
    logic        dnt;
    logic [1:0]  pmt;
    logic [31:0] cntt;

    int checks = 0;
    int failures = 0;

    riscv_test_monitor #(.XLEN(32), .CHANNELS(1), .TIMEOUT_CYCLES(100), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .start(start1), .i_read(rd1), .i_valid(v1), .pc(pc1),
        .status(st1), .done(dn1), .pass_mask(pm1), .fail_chan(fc1), .cycle_count(cnt1));

    riscv_test_monitor #(.XLEN(32), .CHANNELS(4), .TIMEOUT_CYCLES(100), .CNT_W(32)) u4 (
        .clk(clk), .reset(reset), .start(start4), .i_read(rd4), .i_valid(v4), .pc(pc4),
        .status(st4), .done(dn4), .pass_mask(pm4), .fail_chan(fc4), .cycle_count(cnt4));

    riscv_test_monitor #(.XLEN(32), .CHANNELS(2), .TIMEOUT_CYCLES(8), .CNT_W(32)) ut (
        .clk(clk), .reset(reset), .start(startt), .i_read(rdt), .i_valid(vt), .pc(pct),
        .status(stt), .done(dnt), .pass_mask(pmt), .fail_chan(fct), .cycle_count(cntt));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start1 = 0; rd1 = NOP; v1 = 0; pc1 = 0;
        start4 = 0; rd4 = {4{NOP}}; v4 = 0; pc4 = 0;
        startt = 0; rdt = {2{NOP}}; vt = 0; pct = 0;
        tick(); tick();
        checks++;
        if ({st1, dn1, pm1, fc1, cnt1} !== {3'd0, 1'b0, 1'b0, 3'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_u1 got=%h exp=%h", {st1, dn1, pm1, fc1, cnt1}, {3'd0, 1'b0, 1'b0, 3'd0, 32'd0});
        end
        checks++;
        if ({st4, dn4, pm4, fc4, cnt4} !== {3'd0, 1'b0, 4'd0, 3'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_u4 got=%h exp=%h", {st4, dn4, pm4, fc4, cnt4}, {3'd0, 1'b0, 4'd0, 3'd0, 32'd0});
        end
        checks++;
        if ({stt, dnt, pmt, fct, cntt} !== {3'd0, 1'b0, 2'd0, 3'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_ut got=%h exp=%h", {stt, dnt, pmt, fct, cntt}, {3'd0, 1'b0, 2'd0, 3'd0, 32'd0});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({st1, dn1} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL idle_hold got=%h exp=%h", {st1, dn1}, {3'd0, 1'b0});
        end
    endtask

    // Ten NOP edges then PASS; a start pulse mid-run must be ignored.
    task automatic test_pass_single;
        start1 = 1; tick(); start1 = 0;
        checks++;
        if ({st1, dn1, cnt1} !== {3'd1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL pass1_arm got=%h exp=%h", {st1, dn1, cnt1}, {3'd1, 1'b0, 32'd0});
        end
        for (int k = 1; k <= 10; k++) begin
            rd1 = NOP; v1 = 1; start1 = (k == 5);
            tick();
            if (k == 5) begin
                checks++;
                if ({st1, cnt1} !== {3'd1, 32'd5}) begin
                    failures++;
                    $display("FAIL start_ignored got=%h exp=%h", {st1, cnt1}, {3'd1, 32'd5});
                end
            end
        end
        start1 = 0;
        rd1 = PASS; v1 = 1;
        tick();
        rd1 = NOP; v1 = 0;
        checks++;
        if ({st1, dn1, pm1, fc1, cnt1} !== {3'd2, 1'b1, 1'b1, 3'd0, 32'd10}) begin
            failures++;
            $display("FAIL pass1_verdict got=%h exp=%h", {st1, dn1, pm1, fc1, cnt1}, {3'd2, 1'b1, 1'b1, 3'd0, 32'd10});
        end
    endtask

    // Rearm from PASS, three NOPs, FAIL, then X words with valid low.
    task automatic test_fail_single;
        start1 = 1; tick(); start1 = 0;
        checks++;
        if ({st1, dn1, pm1, cnt1} !== {3'd1, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL rearm1 got=%h exp=%h", {st1, dn1, pm1, cnt1}, {3'd1, 1'b0, 1'b0, 32'd0});
        end
        for (int k = 0; k < 3; k++) begin
            rd1 = NOP; v1 = 1; tick();
        end
        rd1 = FAILW; v1 = 1; tick();
        checks++;
        if ({st1, dn1, fc1, cnt1} !== {3'd3, 1'b1, 3'd0, 32'd3}) begin
            failures++;
            $display("FAIL fail1_verdict got=%h exp=%h", {st1, dn1, fc1, cnt1}, {3'd3, 1'b1, 3'd0, 32'd3});
        end
        rd1 = 'x; v1 = 0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if ({st1, dn1, pm1, fc1, cnt1} !== {3'd3, 1'b1, 1'b0, 3'd0, 32'd3}) begin
            failures++;
            $display("FAIL fail1_hold got=%h exp=%h", {st1, dn1, pm1, fc1, cnt1}, {3'd3, 1'b1, 1'b0, 3'd0, 32'd3});
        end
        rd1 = NOP;
    endtask

    // Four channels passing at edges 5, 9, 20, 40; second run fails ch2 at 30.
    task automatic test_multi_channel;
        start4 = 1; tick(); start4 = 0;
        for (int k = 1; k <= 40; k++) begin
            v4 = 0; rd4 = {4{NOP}};
            if (k == 5)  begin v4[0] = 1; rd4[0*32 +: 32] = PASS; end
            if (k == 9)  begin v4[1] = 1; rd4[1*32 +: 32] = PASS; end
            if (k == 20) begin v4[2] = 1; rd4[2*32 +: 32] = PASS; end
            if (k == 40) begin v4[3] = 1; rd4[3*32 +: 32] = PASS; end
            tick();
            if (k == 39) begin
                checks++;
                if ({st4, dn4, pm4, cnt4} !== {3'd1, 1'b0, 4'b0111, 32'd39}) begin
                    failures++;
                    $display("FAIL multi_pre got=%h exp=%h", {st4, dn4, pm4, cnt4}, {3'd1, 1'b0, 4'b0111, 32'd39});
                end
            end
        end
        v4 = 0; rd4 = {4{NOP}};
        checks++;
        if ({st4, dn4, pm4, fc4, cnt4} !== {3'd2, 1'b1, 4'b1111, 3'd0, 32'd39}) begin
            failures++;
            $display("FAIL multi_pass got=%h exp=%h", {st4, dn4, pm4, fc4, cnt4}, {3'd2, 1'b1, 4'b1111, 3'd0, 32'd39});
        end

        start4 = 1; tick(); start4 = 0;
        checks++;
        if ({st4, dn4, pm4, cnt4} !== {3'd1, 1'b0, 4'b0000, 32'd0}) begin
            failures++;
            $display("FAIL multi_rearm got=%h exp=%h", {st4, dn4, pm4, cnt4}, {3'd1, 1'b0, 4'b0000, 32'd0});
        end
        for (int k = 1; k <= 30; k++) begin
            v4 = 0; rd4 = {4{NOP}};
            if (k == 5)  begin v4[0] = 1; rd4[0*32 +: 32] = PASS; end
            if (k == 9)  begin v4[1] = 1; rd4[1*32 +: 32] = PASS; end
            if (k == 20) begin v4[2] = 1; rd4[2*32 +: 32] = PASS; end
            if (k == 30) begin v4[2] = 1; rd4[2*32 +: 32] = FAILW; end
            tick();
        end
        v4 = 0; rd4 = {4{NOP}};
        checks++;
        if ({st4, dn4, pm4, fc4, cnt4} !== {3'd3, 1'b1, 4'b0111, 3'd2, 32'd29}) begin
            failures++;
            $display("FAIL multi_fail got=%h exp=%h", {st4, dn4, pm4, fc4, cnt4}, {3'd3, 1'b1, 4'b0111, 3'd2, 32'd29});
        end
    endtask

    task automatic test_timeout;
        startt = 1; tick(); startt = 0;
        for (int k = 1; k <= 8; k++) begin
            vt = 0; rdt = 'x;
            tick();
            if (k == 7) begin
                checks++;
                if ({stt, dnt, cntt} !== {3'd1, 1'b0, 32'd7}) begin
                    failures++;
                    $display("FAIL timeout_pre got=%h exp=%h", {stt, dnt, cntt}, {3'd1, 1'b0, 32'd7});
                end
            end
        end
        checks++;
        if ({stt, dnt, pmt, cntt} !== {3'd4, 1'b1, 2'b00, 32'd7}) begin
            failures++;
            $display("FAIL timeout_verdict got=%h exp=%h", {stt, dnt, pmt, cntt}, {3'd4, 1'b1, 2'b00, 32'd7});
        end
        // Terminal state ignores signature words.
        vt = 2'b11; rdt = {PASS, FAILW};
        tick(); tick();
        checks++;
        if ({stt, dnt, pmt, fct, cntt} !== {3'd4, 1'b1, 2'b00, 3'd0, 32'd7}) begin
            failures++;
            $display("FAIL timeout_hold got=%h exp=%h", {stt, dnt, pmt, fct, cntt}, {3'd4, 1'b1, 2'b00, 3'd0, 32'd7});
        end
        vt = 0; rdt = {2{NOP}};
        startt = 1; tick(); startt = 0;
        checks++;
        if ({stt, dnt, cntt} !== {3'd1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL timeout_rearm got=%h exp=%h", {stt, dnt, cntt}, {3'd1, 1'b0, 32'd0});
        end
        tick();
        checks++;
        if (cntt !== 32'd1) begin
            failures++;
            $display("FAIL timeout_recount got=%h exp=%h", cntt, 32'd1);
        end
    endtask

    task automatic test_same_edge;
        start4 = 1; tick(); start4 = 0;
        v4 = 4'b0011; rd4 = {NOP, NOP, FAILW, PASS};
        tick();
        v4 = 0; rd4 = {4{NOP}};
        checks++;
        if ({st4, dn4, pm4, fc4, cnt4} !== {3'd3, 1'b1, 4'b0000, 3'd1, 32'd0}) begin
            failures++;
            $display("FAIL same_edge got=%h exp=%h", {st4, dn4, pm4, fc4, cnt4}, {3'd3, 1'b1, 4'b0000, 3'd1, 32'd0});
        end
        // Several failing channels, masked failing channel 0: lowest valid wins.
        start4 = 1; tick(); start4 = 0;
        tick();
        v4 = 4'b1100; rd4 = {FAILW, FAILW, NOP, FAILW};
        tick();
        v4 = 0; rd4 = {4{NOP}};
        checks++;
        if ({st4, fc4, cnt4} !== {3'd3, 3'd2, 32'd1}) begin
            failures++;
            $display("FAIL lowest_fail got=%h exp=%h", {st4, fc4, cnt4}, {3'd3, 3'd2, 32'd1});
        end
    endtask

    task automatic test_async_reset;
        start4 = 1; tick(); start4 = 0;
        v4 = 4'b0001; rd4 = {NOP, NOP, NOP, PASS};
        tick();
        v4 = 0; rd4 = {4{NOP}};
        tick(); tick();
        checks++;
        if ({st4, pm4, cnt4} !== {3'd1, 4'b0001, 32'd3}) begin
            failures++;
            $display("FAIL async_pre got=%h exp=%h", {st4, pm4, cnt4}, {3'd1, 4'b0001, 32'd3});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({st4, dn4, pm4, fc4, cnt4} !== {3'd0, 1'b0, 4'b0000, 3'd0, 32'd0}) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", {st4, dn4, pm4, fc4, cnt4}, {3'd0, 1'b0, 4'b0000, 3'd0, 32'd0});
        end
        #1 reset = 1'b0;
        tick();
        checks++;
        if ({st4, cnt4} !== {3'd0, 32'd0}) begin
            failures++;
            $display("FAIL async_idle got=%h exp=%h", {st4, cnt4}, {3'd0, 32'd0});
        end
    endtask

    // pc reaches 0xA4 on a valid channel at RUN edge 12.
    task automatic test_pc_stop;
        start4 = 1; tick(); start4 = 0;
        for (int k = 1; k <= 100; k++) begin
            v4 = 4'b0010; rd4 = {4{NOP}}; pc4 = '0;
            if (k == 12) pc4[1*32 +: 32] = 32'h0000_00A4;
            tick();
`ifdef RISCV_TEST_MONITOR_PC_STOP_EN
            if (k == 12) begin
                checks++;
                if ({st4, dn4, cnt4} !== {3'd5, 1'b1, 32'd11}) begin
                    failures++;
                    $display("FAIL pc_stop got=%h exp=%h", {st4, dn4, cnt4}, {3'd5, 1'b1, 32'd11});
                end
                break;
            end
`else
            if (k == 12) begin
                checks++;
                if ({st4, dn4, cnt4} !== {3'd1, 1'b0, 32'd12}) begin
                    failures++;
                    $display("FAIL pc_nostop got=%h exp=%h", {st4, dn4, cnt4}, {3'd1, 1'b0, 32'd12});
                end
            end
`endif
        end
        v4 = 0; pc4 = '0;
`ifndef RISCV_TEST_MONITOR_PC_STOP_EN
        checks++;
        if ({st4, dn4, cnt4} !== {3'd4, 1'b1, 32'd99}) begin
            failures++;
            $display("FAIL pc_timeout got=%h exp=%h", {st4, dn4, cnt4}, {3'd4, 1'b1, 32'd99});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_pass_single();
        test_fail_single();
        test_multi_channel();
        test_timeout();
        test_same_edge();
        test_async_reset();
        test_pc_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
